// File: rtl/sprite_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// sprite_scheduler_pkg
// Shared definitions for the sprite scheduler slice:
//   - scheduler FSM state encoding (IDLE, CHECK, SETUP, FETCH, DONE)
//   - sprite geometry constants (16x16 sprite, 8-bit half row, mirrored)
//   - mirror_col(): maps a 0..15 sprite column to its 0..7 row-bit index
// -----------------------------------------------------------------------------
package sprite_scheduler_pkg;

  localparam int SPRITE_H = 16;
  localparam int SPRITE_W = 16;
  localparam int ROW_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SETUP = 3'd2,
    FETCH = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

  // The ROM stores only the left half of each row; the right half replays
  // the same bits in reverse order, so column 8 reuses bit 7 and 15 reuses bit 0.
  function automatic logic [2:0] mirror_col(input logic [3:0] col);
    return col[3] ? ~col[2:0] : col[2:0];
  endfunction

endpackage

// File: rtl/sprite_scheduler_line_unit.sv
// -----------------------------------------------------------------------------
// sprite_line_unit
// Per-slot line renderer: holds one fetched ROM row, an active bit and a
// 5-bit column counter, and emits a registered mirrored pixel.
// Ports:
//   clk, reset   pixel clock, synchronous active-high reset
//   i_load       write i_row into the row buffer and mark the slot active
//   i_clear      mark the slot inactive (not visible / fetch aborted)
//   i_row        ROM row data
//   i_hpos       current pixel column
//   i_x          slot left column
//   o_pix        registered pixel of this slot
// -----------------------------------------------------------------------------
module sprite_line_unit
  import sprite_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_load,
  input  logic                i_clear,
  input  logic [ROW_BITS-1:0] i_row,
  input  logic [9:0]          i_hpos,
  input  logic [9:0]          i_x,
  output logic                o_pix
);

  localparam logic [4:0] XC_IDLE = 5'(SPRITE_W);

  logic [ROW_BITS-1:0] r_row;
  logic                r_active;
  logic [4:0]          r_xc;
  logic                r_pix;
  logic                w_start;
  logic [4:0]          w_xc_eff;

  // Start is folded into the current cycle so column 0 lands one clock
  // after hpos==x instead of two.
  assign w_start  = r_active && (r_xc == XC_IDLE) && (i_hpos == i_x);
  assign w_xc_eff = w_start ? 5'd0 : r_xc;

  // Row buffer, active flag, column counter and pixel register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row    <= '0;
      r_active <= 1'b0;
      r_xc     <= XC_IDLE;
      r_pix    <= 1'b0;
    end else if (i_load) begin
      r_row    <= i_row;
      r_active <= 1'b1;
      r_xc     <= XC_IDLE;
      r_pix    <= 1'b0;
    end else begin
      if (i_clear) begin
        r_active <= 1'b0;
      end else begin
        r_active <= r_active;
      end
      if (!w_xc_eff[4]) begin
        r_pix <= r_row[mirror_col(w_xc_eff[3:0])];
        r_xc  <= w_xc_eff + 5'd1;
      end else begin
        r_pix <= 1'b0;
        r_xc  <= r_xc;
      end
    end
  end

  assign o_pix = r_pix;

endmodule

// File: rtl/sprite_scheduler.sv
// -----------------------------------------------------------------------------
// sprite_scheduler
// Shares one mirrored 16x16 sprite ROM port among NUM_SPRITES slots. On each
// load-window rising edge it checks every slot against the next scanline and
// fetches the needed ROM row; during the line it draws all slots and merges
// them into one pixel plus the lowest lit slot index.
// Optional feature macro: SPRITE_COLLISION_EN (sticky per-frame overlap flag;
// when undefined o_collision is tied low).
// Ports:
//   clk, reset            pixel clock, synchronous active-high reset
//   i_hpos, i_vpos        current pixel column / scanline
//   i_load_win            ROM fetch window (hsync region)
//   i_sprite_x/y          slot i position at [10i+9:10i]
//   i_sprite_en           slot enables
//   o_rom_slot/o_rom_yofs ROM address; i_rom_bits valid the following cycle
//   o_gfx, o_gfx_slot     merged pixel and lowest lit slot
//   o_busy                fetch sequence running
//   o_overrun             1-cycle pulse when the window closed mid-sequence
//   o_collision           sticky overlap flag (feature build only)
// -----------------------------------------------------------------------------
module sprite_scheduler
  import sprite_scheduler_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SLOT_W      = 2,
  parameter int V_LAST      = 524
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [9:0]                 i_hpos,
  input  logic [9:0]                 i_vpos,
  input  logic                       i_load_win,
  input  logic [10*NUM_SPRITES-1:0]  i_sprite_x,
  input  logic [10*NUM_SPRITES-1:0]  i_sprite_y,
  input  logic [NUM_SPRITES-1:0]     i_sprite_en,
  output logic [SLOT_W-1:0]          o_rom_slot,
  output logic [3:0]                 o_rom_yofs,
  input  logic [ROW_BITS-1:0]        i_rom_bits,
  output logic                       o_gfx,
  output logic [SLOT_W-1:0]          o_gfx_slot,
  output logic                       o_busy,
  output logic                       o_overrun,
  output logic                       o_collision
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SPRITES - 1);

  sched_state_t            r_state;
  logic [SLOT_W-1:0]       r_slot;
  logic                    r_load_prev;
  logic                    r_busy;
  logic                    r_overrun;
  logic [SLOT_W-1:0]       r_rom_slot;
  logic [3:0]              r_rom_yofs;

  logic [9:0]              w_tline;
  logic [9:0]              w_sel_y;
  logic [9:0]              w_dy;
  logic                    w_vis;
  logic                    w_rise;
  logic                    w_abort;
  logic [NUM_SPRITES-1:0]  w_load;
  logic [NUM_SPRITES-1:0]  w_clear;
  logic [NUM_SPRITES-1:0]  w_pix;
  logic                    w_gfx;
  logic [SLOT_W-1:0]       w_gfx_slot;

  // Visibility of the slot under inspection, against the line being prepared.
  assign w_tline = (i_vpos == 10'(V_LAST)) ? 10'd0 : i_vpos + 10'd1;
  assign w_sel_y = i_sprite_y[int'(r_slot)*10 +: 10];
  assign w_dy    = w_tline - w_sel_y;
  assign w_vis   = i_sprite_en[r_slot] && (w_dy < 10'(SPRITE_H));
  assign w_rise  = i_load_win && !r_load_prev;
  assign w_abort = ((r_state == CHECK) || (r_state == SETUP) || (r_state == FETCH)) && !i_load_win;

  // Per-slot load/clear strobes; an abort drops the current and every unchecked slot.
  always_comb begin
    w_load  = '0;
    w_clear = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      w_load[i]  = (r_state == FETCH) && i_load_win && (r_slot == SLOT_W'(i));
      w_clear[i] = ((r_state == CHECK) && i_load_win && !w_vis && (r_slot == SLOT_W'(i)))
                 || (w_abort && (SLOT_W'(i) >= r_slot));
    end
  end

  // Fetch sequencer with registered busy/overrun/ROM address outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_slot      <= '0;
      r_load_prev <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      r_rom_slot  <= '0;
      r_rom_yofs  <= 4'd0;
    end else begin
      r_load_prev <= i_load_win;
      r_overrun   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= CHECK;
            r_slot  <= '0;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        CHECK: begin
          if (w_abort) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_overrun <= 1'b1;
          end else if (w_vis) begin
            r_state <= SETUP;
          end else if (r_slot == LAST_SLOT) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
          end else begin
            r_slot  <= r_slot + 1'b1;
          end
        end
        SETUP: begin
          if (w_abort) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_overrun <= 1'b1;
          end else begin
            r_rom_slot <= r_slot;
            r_rom_yofs <= w_dy[3:0];
            r_state    <= FETCH;
          end
        end
        FETCH: begin
          if (w_abort) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_overrun <= 1'b1;
          end else if (r_slot == LAST_SLOT) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
          end else begin
            r_slot  <= r_slot + 1'b1;
            r_state <= CHECK;
          end
        end
        DONE: begin
          r_busy <= 1'b0;
          if (!i_load_win) begin
            r_state <= IDLE;
          end else begin
            r_state <= DONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_slot
    sprite_line_unit u_line (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load[g]),
      .i_clear (w_clear[g]),
      .i_row   (i_rom_bits),
      .i_hpos  (i_hpos),
      .i_x     (i_sprite_x[10*g +: 10]),
      .o_pix   (w_pix[g])
    );
  end

  // Priority merge: scanning downward leaves the lowest lit slot index.
  always_comb begin
    w_gfx      = |w_pix;
    w_gfx_slot = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      w_gfx_slot = w_pix[i] ? SLOT_W'(i) : w_gfx_slot;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic [3:0] w_pix_cnt;
  logic       w_overlap;
  logic       r_collision;

  // Count lit slots this pixel.
  always_comb begin
    w_pix_cnt = 4'd0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      w_pix_cnt = w_pix_cnt + {3'd0, w_pix[i]};
    end
  end

  assign w_overlap = (w_pix_cnt >= 4'd2);

  // Sticky overlap flag, cleared at the frame origin; a new overlap wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_collision <= 1'b0;
    end else if (w_overlap) begin
      r_collision <= 1'b1;
    end else if ((i_vpos == 10'd0) && (i_hpos == 10'd0)) begin
      r_collision <= 1'b0;
    end else begin
      r_collision <= r_collision;
    end
  end

  // The live overlap is ORed in so the flag rises on the overlapping pixel itself.
  assign o_collision = r_collision | w_overlap;
`else
  assign o_collision = 1'b0;
`endif

  assign o_rom_slot = r_rom_slot;
  assign o_rom_yofs = r_rom_yofs;
  assign o_gfx      = w_gfx;
  assign o_gfx_slot = w_gfx_slot;
  assign o_busy     = r_busy;
  assign o_overrun  = r_overrun;

endmodule
